// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial ripple adder (one full-adder cell, LSB first) with
//            valid/ready handshakes on operand and result sides.
//            Optional signed-overflow output: define SERIAL_ADDER_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int              CW     = $clog2(W) + 1;
    localparam logic [CW-1:0]   C_LAST = CW'(W - 1);
    localparam logic [CW-1:0]   C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_ra;
    logic [W-1:0]    r_rb;
    logic [W-1:0]    r_rs;
    logic            r_c;
    logic [CW-1:0]   r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic            r_ovf;
`endif

    logic            w_s;
    logic            w_c_next;
    logic [W-1:0]    w_rs_next;

    assign w_s      = r_ra[0] ^ r_rb[0] ^ r_c;
    assign w_c_next = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_c) | (r_rb[0] & r_c);

    // New sum bit enters at the MSB; after W steps bit 0 sits at the LSB.
    generate
        if (W == 1) begin : g_rs_w1
            assign w_rs_next = w_s;
        end else begin : g_rs_wn
            assign w_rs_next = {w_s, r_rs[W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rs    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_rs    <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_rs  <= w_rs_next;
                    r_c   <= w_c_next;
                    r_cnt <= r_cnt + C_ONE;
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into MSB differs from carry out of MSB.
                        r_ovf   <= r_c ^ w_c_next;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_rs;
    assign cout      = r_c;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed vector bench for serial_adder (W=8 and W=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         in_valid1  = 1'b0;
    logic         in_ready1;
    logic [0:0]   a1         = 1'b0;
    logic [0:0]   b1         = 1'b0;
    logic         cin1       = 1'b0;
    logic         out_valid1;
    logic         out_ready1 = 1'b0;
    logic [0:0]   sum1;
    logic         cout1;
    logic         ovf1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    serial_adder #(.W(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           backp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vcin, input logic [W-1:0] es,
                         input logic eco, input logic eov, input int backp);
        int lat;
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", int'(in_ready), 1);
        a        = va;
        b        = vb;
        cin      = vcin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("in_ready_in_run", int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("latency", lat, W);
        check("sum", int'(sum), int'(es));
        check("cout", int'(cout), int'(eco));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", int'(ovf), int'(eov));
`endif
        for (int i = 0; i < backp; i++) begin
            tick();
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_sum", int'(sum), int'(es));
            check("bp_cout", int'(cout), int'(eco));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{a:8'hFF, b:8'h01, cin:1'b0, s:8'h00, co:1'b1, ov:1'b0, backp:0};
        vecs[1] = '{a:8'h7F, b:8'h01, cin:1'b0, s:8'h80, co:1'b0, ov:1'b1, backp:0};
        vecs[2] = '{a:8'h80, b:8'h80, cin:1'b0, s:8'h00, co:1'b1, ov:1'b1, backp:0};
        vecs[3] = '{a:8'h00, b:8'h00, cin:1'b1, s:8'h01, co:1'b0, ov:1'b0, backp:0};
        vecs[4] = '{a:8'hA5, b:8'h5A, cin:1'b1, s:8'h00, co:1'b1, ov:1'b0, backp:5};
        vecs[5] = '{a:8'h3C, b:8'h0F, cin:1'b0, s:8'h4B, co:1'b0, ov:1'b0, backp:0};

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", int'(ovf), 0);
`endif

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s,
                  vecs[i].co, vecs[i].ov, vecs[i].backp);
        end

        // in_valid with other operands during RUN must be ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 8'hEE; b = 8'hEE; cin = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        seen = 3;
        while (!out_valid && seen < 50) begin
            tick();
            seen++;
        end
        check("ignore_latency", seen, W);
        check("ignore_sum", int'(sum), 32'h46);
        check("ignore_cout", int'(cout), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ignore_idle", int'(in_ready), 1);

        // Reset after the 3rd RUN edge aborts the operation.
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sum", int'(sum), 0);
        check("abort_cout", int'(cout), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);
        do_op(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0, 0);

        // W=1 instance: single RUN cycle.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check("w1_out_valid_run", int'(out_valid1), 0);
        tick();
        check("w1_out_valid", int'(out_valid1), 1);
        check("w1_sum", int'(sum1), 1);
        check("w1_cout", int'(cout1), 1);
`ifdef SERIAL_ADDER_OVF_EN
        check("w1_ovf", int'(ovf1), 0);
`endif
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("w1_in_ready", int'(in_ready1), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder with valid/ready handshakes on both sides. It accepts two W-bit operands plus carry-in and computes the sum one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It then presents the W-bit sum and carry-out until the downstream side accepts it. It is the addition-side counterpart to the team's subtractor cells and serves as the area-minimal arithmetic stage in multi-cycle datapaths.

## Interface
- W, default 8: operand/sum width in bits; legal range W >= 1.
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  reset, synchronous and active-high (one clock; synchronous active-high reset, fixed).
- in_valid  input  1  upstream offers a, b, cin.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- a  input  W  operand A, unsigned/two's-complement agnostic.
- b  input  W  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum/cout valid; equals (state == DONE).
- out_ready  input  1  downstream accepts result.
- sum  output  W  a + b + cin, modulo 2^W.
- cout  output  1  carry out of bit W-1.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- Registers: shift registers ra and rb (W each), sum shift register rs (W), carry flip-flop c, bit counter cnt (width clog2(W)+1), and 2-bit state.
- State IDLE: in_ready=1. On in_valid && in_ready: ra<=a, rb<=b, c<=cin, cnt<=0, rs<=0, state->RUN.
- State RUN: each cycle:
  - s = ra[0]^rb[0]^c and c <= ra[0]&rb[0] | ra[0]&c | rb[0]&c.
  - ra and rb shift right by 1; rs <= {s, rs[W-1:1]}; cnt <= cnt+1.
  - When cnt == W-1, state->DONE after this edge.
- State DONE: sum = rs and cout = c. Both are held stable while out_valid=1. On out_ready, state->IDLE.
- in_valid is ignored in RUN and DONE. Operand inputs are sampled only at the accepting edge.
- out_ready is ignored outside DONE.
- Unused state encoding: next edge -> IDLE.
- Reset: state=IDLE, ra=rb=rs=0, c=0, cnt=0, ovf register=0. Hence sum=0, cout=0, out_valid=0, in_ready=1 in the first cycle after rst deasserts.
- Reset mid-RUN or in DONE aborts the operation. No out_valid is produced for the aborted operands.
- While rst=1, handshakes on either side are ignored.

## Timing
- Acceptance edge T0: state becomes RUN.
- Edges T0+1 .. T0+W: one bit each.
- out_valid rises after edge T0+W, i.e. W cycles after the accept cycle.
- Minimum issue interval is W+2 cycles: accept, W run cycles, one DONE cycle with out_ready=1, then IDLE.
- No back-to-back accept from DONE.
- W=1: a single RUN cycle. cnt compares against 0 on the first RUN edge.
- out_valid stays asserted indefinitely under backpressure. sum and cout do not change during this time.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds output port ovf and a flip-flop that captures c ^ carry_out at the bit W-1 step, i.e. carry into MSB XOR carry out of MSB.
  - ovf is valid with out_valid and reset to 0.
- Undefined: the ovf port and its flip-flop do not exist. All other behaviour and timing are identical.

## Test plan
- W=8, a=0xFF, b=0x01, cin=0 -> out_valid exactly 8 cycles after the accept cycle; sum=0x00, cout=1, ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1 (ovf checked only with the macro defined).
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. Also a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> sum, cout and out_valid stay constant and in_ready stays 0. Assert out_ready -> IDLE on the next edge, in_ready=1.
- Protocol: pulse in_valid with different operands during RUN -> ignored, and the result matches the first operands. Assert rst for 1 cycle after the 3rd RUN edge -> all outputs 0 and in_ready=1, with no out_valid. A new operation then completes correctly.
- W=1 build: a=1, b=1, cin=1 -> out_valid 1 cycle after accept; sum=1, cout=1.
